// File: rtl/k423_dmem_responder.sv
// rtl/k423_dmem_responder.sv - data-memory responder with byte strobes, init clear and fixed-latency responses
module k423_dmem_responder #(
  parameter int DEPTH        = 1024,
  parameter int LATENCY      = 1,
  parameter int CORE_ADDR_W  = 32,
  parameter int CORE_XLEN    = 32,
  parameter int CORE_FETCH_W = 32,
  parameter int LS_SIZE_W    = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    mem_data_req_vld_i,
  output logic                    mem_data_req_rdy_o,
  input  logic                    mem_data_req_wen_i,
  input  logic [CORE_ADDR_W-1:0]  mem_data_req_addr_i,
  input  logic [LS_SIZE_W-1:0]    mem_data_req_size_i,
  input  logic [CORE_XLEN-1:0]    mem_data_req_wdata_i,
  output logic                    mem_data_rsp_vld_o,
  output logic [CORE_FETCH_W-1:0] mem_data_rsp_rdata_o,
  output logic                    mem_data_rsp_err_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [LS_SIZE_W-1:0] LS_SIZE_BYTE = LS_SIZE_W'(0);
  localparam logic [LS_SIZE_W-1:0] LS_SIZE_HALF = LS_SIZE_W'(1);
  localparam logic [LS_SIZE_W-1:0] LS_SIZE_WORD = LS_SIZE_W'(2);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     clr_idx;
  logic                 clr_en;

  logic [31:0]          mem [DEPTH];

  logic [CORE_ADDR_W-3:0] word_idx;
  logic [IDX_W-1:0]     widx;
  logic [1:0]           off;
  logic                 oor;
  logic                 misal;
  logic                 req_err;
  logic                 acc;
  logic                 wr_en;
  logic [3:0]           strb;
  logic [31:0]          wdata_w;
  logic [31:0]          lane;
  logic [CORE_FETCH_W-1:0] stage_rdata;

  logic                    pipe_vld   [LATENCY];
  logic                    pipe_err   [LATENCY];
  logic [CORE_FETCH_W-1:0] pipe_rdata [LATENCY];

  // State register: reset always restarts the clear walk
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= ST_INIT;
    else       state <= state_nxt;
  end

  // Clear index walks the array once; wraps harmlessly since DEPTH is a power of two
  always_ff @(posedge clk_i) begin
    if (rst_i)                clr_idx <= '0;
    else if (state == ST_INIT) clr_idx <= clr_idx + 1'b1;
  end

  // Next state: leave INIT after the last word has been cleared
  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT: if (clr_idx == IDX_W'(DEPTH - 1)) state_nxt = ST_RUN;
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_INIT;
    endcase
  end

  // FSM outputs: ready only once the array is clean
  always_comb begin
    mem_data_req_rdy_o = (state == ST_RUN);
    clr_en             = (state == ST_INIT);
  end

  assign word_idx = mem_data_req_addr_i[CORE_ADDR_W-1:2];
  assign widx     = word_idx[IDX_W-1:0];
  assign off      = mem_data_req_addr_i[1:0];
  assign oor      = (word_idx >= (CORE_ADDR_W-2)'(DEPTH));
  assign wdata_w  = 32'(mem_data_req_wdata_i);
  assign lane     = wdata_w << {off, 3'b000};
  assign req_err  = oor | misal;
  // A request on a reset edge must not touch the array or pipeline
  assign acc      = mem_data_req_vld_i & mem_data_req_rdy_o & ~rst_i;
  assign wr_en    = acc & mem_data_req_wen_i & ~req_err;

  // Size decode: alignment check and byte strobes; illegal encodings are misaligned
  always_comb begin
    misal = 1'b1;
    strb  = 4'b0000;
    case (mem_data_req_size_i)
      LS_SIZE_BYTE: begin misal = 1'b0;                  strb = 4'b0001 << off; end
      LS_SIZE_HALF: begin misal = off[0];                strb = 4'b0011 << off; end
      LS_SIZE_WORD: begin misal = (off != 2'b00);        strb = 4'b1111;        end
      default:      begin misal = 1'b1;                  strb = 4'b0000;        end
    endcase
  end

  // Array write port: INIT clears one word per cycle, RUN merges strobed bytes
  always_ff @(posedge clk_i) begin
    if (clr_en) begin
      mem[clr_idx] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) mem[widx][8*b +: 8] <= lane[8*b +: 8];
      end
    end
  end

  // Loads sample the word at the accept edge; stores and errors return zero
  always_comb begin
    stage_rdata = '0;
    if (acc && !req_err && !mem_data_req_wen_i) stage_rdata = CORE_FETCH_W'(mem[widx]);
  end

  // Response shift register: advances every cycle, reset drops everything in flight
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe_vld[i]   <= 1'b0;
        pipe_err[i]   <= 1'b0;
        pipe_rdata[i] <= '0;
      end
    end else begin
      pipe_vld[0]   <= acc;
      pipe_err[0]   <= acc & req_err;
      pipe_rdata[0] <= stage_rdata;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_vld[i]   <= pipe_vld[i-1];
        pipe_err[i]   <= pipe_err[i-1];
        pipe_rdata[i] <= pipe_rdata[i-1];
      end
    end
  end

  assign mem_data_rsp_vld_o   = pipe_vld[LATENCY-1];
  assign mem_data_rsp_err_o   = pipe_err[LATENCY-1];
  assign mem_data_rsp_rdata_o = pipe_rdata[LATENCY-1];

endmodule
